// File: rtl/capture_stream_ctrl.sv
// ---------------------------------------------------------------------------
// capture_stream_ctrl
//
// Capture-then-stream controller sitting between the SPI ADC reader and the
// Arduino SPI writer. A start pulse collects DEPTH samples into an internal
// buffer, then the samples are forwarded oldest-first, one frame per
// tx_req/tx_done handshake. Optional continuous mode re-arms a new capture
// after every completed transmit.
//
// Optional feature (compile-time macro THRESH_TRIG_EN):
//   When defined, adds input trig_level and an ARM phase entered on start.
//   In ARM, conversions are requested as in ACQ but samples below trig_level
//   (unsigned) are discarded; the first sample >= trig_level is stored as
//   sample 0 and capture proceeds normally. Continuous re-arm goes through
//   ARM. When undefined, capture begins with the first conversion.
//
// Parameters:
//   DATA_W  sample / frame payload width
//   DEPTH   samples per capture (2..1024)
//   CNT_W   width of sample_cnt / sent_cnt
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-low reset
//   start       pulse, begins a capture from IDLE (ignored elsewhere)
//   abort       pulse, returns to IDLE from any state (highest priority)
//   continuous  re-arm after transmit; sampled when the transmit completes
//   trig_level  trigger threshold (THRESH_TRIG_EN only)
//   adc_req     conversion request to the ADC reader
//   adc_done    conversion finished pulse, adc_data valid in the same cycle
//   adc_data    converted sample
//   tx_req      frame request to the Arduino writer
//   tx_data     frame payload, stable while tx_req=1
//   tx_done     frame finished pulse
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the last sample of a capture is sent
//   sample_cnt  samples stored in the current capture
//   sent_cnt    samples transmitted in the current capture
// ---------------------------------------------------------------------------
module capture_stream_ctrl #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 100,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
`ifdef THRESH_TRIG_EN
  input  logic [DATA_W-1:0] trig_level,
`endif
  output logic              adc_req,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  sent_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

`ifdef THRESH_TRIG_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQ     = 3'd1,
    ST_ACQ_GAP = 3'd2,
    ST_TX      = 3'd3,
    ST_TX_GAP  = 3'd4,
    ST_DONE    = 3'd5,
    ST_ARM     = 3'd6,
    ST_ARM_GAP = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQ     = 3'd1,
    ST_ACQ_GAP = 3'd2,
    ST_TX      = 3'd3,
    ST_TX_GAP  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;
`endif

  state_t state_r;
  state_t next_state_s;

  // Capture buffer; contents are deliberately left unreset.
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [PTR_W-1:0] wp_r;
  logic [PTR_W-1:0] rp_r;
  logic [CNT_W-1:0] sample_cnt_r;
  logic [CNT_W-1:0] sent_cnt_r;

  logic              adc_req_r;
  logic              tx_req_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              busy_r;
  logic              done_r;

  // Decoded per-cycle actions from the next-state logic.
  logic store_s;   // write adc_data into the buffer and count it
  logic send_s;    // one frame has been accepted by the writer
  logic clear_s;   // new capture: zero counters and pointers
  logic tx_enter_s;

  // Capture start state: ARM when the threshold trigger is built in.
  state_t capture_entry_s;

`ifdef THRESH_TRIG_EN
  assign capture_entry_s = ST_ARM;
`else
  assign capture_entry_s = ST_ACQ;
`endif

  // Next-state and action decode; abort overrides every other event.
  always_comb begin
    next_state_s = state_r;
    store_s      = 1'b0;
    send_s       = 1'b0;
    clear_s      = 1'b0;
    if (abort) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            clear_s      = 1'b1;
            next_state_s = capture_entry_s;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_ACQ: begin
          if (adc_done) begin
            store_s = 1'b1;
            // Counter still holds the pre-write value here.
            if (sample_cnt_r == CNT_W'(DEPTH - 1)) begin
              next_state_s = ST_TX;
            end else begin
              next_state_s = ST_ACQ_GAP;
            end
          end else begin
            next_state_s = ST_ACQ;
          end
        end
        ST_ACQ_GAP: begin
          next_state_s = ST_ACQ;
        end
        ST_TX: begin
          if (tx_done) begin
            send_s = 1'b1;
            if (sent_cnt_r == CNT_W'(DEPTH - 1)) begin
              next_state_s = ST_DONE;
            end else begin
              next_state_s = ST_TX_GAP;
            end
          end else begin
            next_state_s = ST_TX;
          end
        end
        ST_TX_GAP: begin
          next_state_s = ST_TX;
        end
        ST_DONE: begin
          if (continuous) begin
            clear_s      = 1'b1;
            next_state_s = capture_entry_s;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
`ifdef THRESH_TRIG_EN
        ST_ARM: begin
          if (adc_done) begin
            if (adc_data >= trig_level) begin
              // Trigger sample becomes sample 0; DEPTH >= 2 so capture
              // never completes on this write.
              store_s      = 1'b1;
              next_state_s = ST_ACQ_GAP;
            end else begin
              next_state_s = ST_ARM_GAP;
            end
          end else begin
            next_state_s = ST_ARM;
          end
        end
        ST_ARM_GAP: begin
          next_state_s = ST_ARM;
        end
`endif
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Frame payload is loaded only on the edge that enters TX.
  assign tx_enter_s = (next_state_s == ST_TX) && (state_r != ST_TX);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Write and read pointers plus the two status counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_r         <= {PTR_W{1'b0}};
      rp_r         <= {PTR_W{1'b0}};
      sample_cnt_r <= {CNT_W{1'b0}};
      sent_cnt_r   <= {CNT_W{1'b0}};
    end else if (clear_s) begin
      wp_r         <= {PTR_W{1'b0}};
      rp_r         <= {PTR_W{1'b0}};
      sample_cnt_r <= {CNT_W{1'b0}};
      sent_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (store_s) begin
        // Explicit wrap keeps non-power-of-two depths inside the array.
        wp_r         <= (wp_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wp_r + PTR_W'(1);
        sample_cnt_r <= sample_cnt_r + CNT_W'(1);
      end else begin
        wp_r         <= wp_r;
        sample_cnt_r <= sample_cnt_r;
      end
      if (send_s) begin
        rp_r         <= (rp_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rp_r + PTR_W'(1);
        sent_cnt_r   <= sent_cnt_r + CNT_W'(1);
      end else begin
        rp_r         <= rp_r;
        sent_cnt_r   <= sent_cnt_r;
      end
    end
  end

  // Sample buffer write port.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wp_r] <= adc_data;
    end
  end

  // Registered handshake and status outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adc_req_r <= 1'b0;
      tx_req_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
`ifdef THRESH_TRIG_EN
      adc_req_r <= (next_state_s == ST_ACQ) || (next_state_s == ST_ARM);
`else
      adc_req_r <= (next_state_s == ST_ACQ);
`endif
      // Low on the TX entry cycle (payload settling), then held until
      // tx_done or abort moves the FSM out of TX.
      tx_req_r  <= (state_r == ST_TX) && (next_state_s == ST_TX);
      busy_r    <= (next_state_s != ST_IDLE);
      done_r    <= (next_state_s == ST_DONE);
    end
  end

  // Frame payload register, stable for the whole tx_req window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_r <= {DATA_W{1'b0}};
    end else if (tx_enter_s) begin
      tx_data_r <= mem_r[rp_r];
    end else begin
      tx_data_r <= tx_data_r;
    end
  end

  assign adc_req    = adc_req_r;
  assign tx_req     = tx_req_r;
  assign tx_data    = tx_data_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign sample_cnt = sample_cnt_r;
  assign sent_cnt   = sent_cnt_r;

endmodule

// File: tb/tb_capture_stream_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for capture_stream_ctrl (DATA_W=12, DEPTH=4).
// Peers (ADC reader, Arduino writer) are emulated with random response
// latency; the expected frame stream comes from a queue model of the
// capture buffer (optionally with threshold hunting when THRESH_TRIG_EN).
// ---------------------------------------------------------------------------
module tb_capture_stream_ctrl;

  localparam int DW = 12;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          continuous;
  logic          adc_req;
  logic          adc_done;
  logic [DW-1:0] adc_data;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          tx_done;
  logic          busy;
  logic          done;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] sent_cnt;
`ifdef THRESH_TRIG_EN
  logic [DW-1:0] trig_level;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int done_seen = 0;

  // Reference model: samples held in capture order.
  logic [DW-1:0] model_q [$];
  bit            hunting = 1'b0;
  bit            trig_mode = 1'b0;
  logic [DW-1:0] trig_model = 12'h000;
  logic [DW-1:0] vals [16];

  capture_stream_ctrl #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
`ifdef THRESH_TRIG_EN
    .trig_level (trig_level),
`endif
    .adc_req    (adc_req),
    .adc_done   (adc_done),
    .adc_data   (adc_data),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .sent_cnt   (sent_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_start();
    model_q.delete();
    hunting = trig_mode;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_adc_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (adc_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_total++;
      $display("FAIL adc_req_timeout: got adc_req=%0b expected 1", adc_req);
    end
  endtask

  task automatic wait_tx_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (tx_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_total++;
      $display("FAIL tx_req_timeout: got tx_req=%0b expected 1", tx_req);
    end
  endtask

  // Emulated ADC reader: answer one request after a random latency.
  task automatic feed_adc(input logic [DW-1:0] v);
    bit ok;
    wait_adc_req(ok);
    if (!ok) return;
    repeat ($urandom_range(0, 2)) tick();
    adc_done = 1'b1;
    adc_data = v;
    tick();
    adc_done = 1'b0;
    adc_data = DW'($urandom);
    if (!(hunting && (v < trig_model))) begin
      hunting = 1'b0;
      model_q.push_back(v);
    end
  endtask

  // Serve vals[first..first+n-1]; checks gap/counters after each store.
  task automatic capture(input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      feed_adc(vals[k]);
      if (model_q.size() < DP) begin
        n_total++;
        if (adc_req !== 1'b0 || sample_cnt !== CW'(model_q.size()))
          $display("FAIL acq_gap: got adc_req=%0b cnt=%0d expected 0 cnt=%0d",
                   adc_req, sample_cnt, model_q.size());
        else n_pass++;
      end else begin
        n_total++;
        if (sample_cnt !== CW'(DP) || tx_req !== 1'b0 || adc_req !== 1'b0)
          $display("FAIL acq_full: got cnt=%0d tx_req=%0b adc_req=%0b expected %0d 0 0",
                   sample_cnt, tx_req, adc_req, DP);
        else n_pass++;
        tick();
        n_total++;
        if (tx_req !== 1'b1)
          $display("FAIL tx_latency: got tx_req=%0b expected 1", tx_req);
        else n_pass++;
      end
    end
  endtask

  // Emulated Arduino writer: accept nframes frames, compare against model.
  task automatic stream(input int nframes, input bit cont);
    bit ok;
    logic [DW-1:0] got, exp;
    for (int k = 0; k < nframes; k++) begin
      wait_tx_req(ok);
      if (!ok) return;
      got = tx_data;
      exp = (model_q.size() > 0) ? model_q.pop_front() : 12'hxxx;
      n_total++;
      if (got !== exp || sent_cnt !== CW'(k))
        $display("FAIL frame%0d: got data=%0h sent=%0d expected %0h sent=%0d",
                 k, got, sent_cnt, exp, k);
      else n_pass++;
      repeat ($urandom_range(0, 2)) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (k < DP - 1) begin
        n_total++;
        if (tx_req !== 1'b0 || sent_cnt !== CW'(k + 1))
          $display("FAIL tx_gap: got tx_req=%0b sent=%0d expected 0 %0d",
                   tx_req, sent_cnt, k + 1);
        else n_pass++;
      end
    end
    if (nframes == DP) begin
      n_total++;
      if (done !== 1'b1 || sent_cnt !== CW'(DP) || tx_req !== 1'b0)
        $display("FAIL done_pulse: got done=%0b sent=%0d tx_req=%0b expected 1 %0d 0",
                 done, sent_cnt, tx_req, DP);
      else n_pass++;
      tick();
      n_total++;
      if (cont) begin
        if (done !== 1'b0 || adc_req !== 1'b1 || busy !== 1'b1 || sample_cnt !== CW'(0))
          $display("FAIL rearm: got done=%0b adc_req=%0b busy=%0b cnt=%0d expected 0 1 1 0",
                   done, adc_req, busy, sample_cnt);
        else n_pass++;
      end else begin
        if (done !== 1'b0 || busy !== 1'b0 || adc_req !== 1'b0)
          $display("FAIL after_done: got done=%0b busy=%0b adc_req=%0b expected 0 0 0",
                   done, busy, adc_req);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    n_total++;
    if ({adc_req, tx_req, busy, done} !== 4'b0000 || tx_data !== 12'h000 ||
        sample_cnt !== 3'd0 || sent_cnt !== 3'd0)
      $display("FAIL reset_held: got req=%0b%0b busy=%0b done=%0b data=%0h cnt=%0d/%0d expected zeros",
               adc_req, tx_req, busy, done, tx_data, sample_cnt, sent_cnt);
    else n_pass++;
    rst = 1'b1;
    repeat (2) tick();
    n_total++;
    if ({adc_req, tx_req, busy, done} !== 4'b0000 || sample_cnt !== 3'd0)
      $display("FAIL reset_idle: got req=%0b%0b busy=%0b done=%0b expected 0",
               adc_req, tx_req, busy, done);
    else n_pass++;
  endtask

  task automatic test_basic();
    int d0;
    for (int i = 0; i < DP; i++) vals[i] = DW'(i + 1);
    d0 = done_seen;
    model_start();
    pulse_start();
    n_total++;
    if (adc_req !== 1'b1 || busy !== 1'b1 || sample_cnt !== 3'd0)
      $display("FAIL start_latency: got adc_req=%0b busy=%0b cnt=%0d expected 1 1 0",
               adc_req, busy, sample_cnt);
    else n_pass++;
    capture(0, DP);
    stream(DP, 1'b0);
    n_total++;
    if (done_seen - d0 !== 1)
      $display("FAIL basic_done_count: got %0d expected 1", done_seen - d0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DP; i++) vals[i] = DW'($urandom);
      model_start();
      pulse_start();
      capture(0, DP);
      stream(DP, 1'b0);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int d0;
    bit bad;
    vals[0] = 12'h0A1;
    d0 = done_seen;
    model_start();
    pulse_start();
    feed_adc(vals[0]);
    wait_adc_req(ok);
    adc_done = 1'b1;
    adc_data = 12'h0B2;
    abort    = 1'b1;
    tick();
    adc_done = 1'b0;
    abort    = 1'b0;
    n_total++;
    if (adc_req !== 1'b0 || sample_cnt !== 3'd1 || busy !== 1'b0 || tx_req !== 1'b0)
      $display("FAIL abort: got adc_req=%0b cnt=%0d busy=%0b expected 0 1 0",
               adc_req, sample_cnt, busy);
    else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (adc_req !== 1'b0 || busy !== 1'b0 || sample_cnt !== 3'd1) bad = 1'b1;
    end
    n_total++;
    if (bad || done_seen != d0)
      $display("FAIL abort_idle: got bad=%0b dones=%0d expected 0 0", bad, done_seen - d0);
    else n_pass++;
  endtask

  task automatic test_continuous();
    int d0;
    d0 = done_seen;
    continuous = 1'b1;
    for (int i = 0; i < DP; i++) vals[i] = 12'hA00 + DW'(i);
    model_start();
    pulse_start();
    capture(0, DP);
    stream(DP, 1'b1);
    // Re-arm already happened in hardware; mirror it in the model.
    model_start();
    continuous = 1'b0;
    for (int i = 0; i < DP; i++) vals[i] = 12'hB00 + DW'(i);
    capture(0, DP);
    stream(DP, 1'b0);
    n_total++;
    if (done_seen - d0 !== 2)
      $display("FAIL cont_done_count: got %0d expected 2", done_seen - d0);
    else n_pass++;
  endtask

  task automatic test_stray();
    bit ok;
    logic [DW-1:0] held;
    for (int i = 0; i < DP; i++) vals[i] = DW'($urandom);
    model_start();
    pulse_start();
    capture(0, 1);
    wait_adc_req(ok);
    tx_done = 1'b1;
    start   = 1'b1;
    tick();
    tx_done = 1'b0;
    start   = 1'b0;
    n_total++;
    if (sample_cnt !== 3'd1 || adc_req !== 1'b1 || sent_cnt !== 3'd0 || tx_req !== 1'b0)
      $display("FAIL stray_tx_done: got cnt=%0d adc_req=%0b sent=%0d expected 1 1 0",
               sample_cnt, adc_req, sent_cnt);
    else n_pass++;
    capture(1, DP - 1);
    wait_tx_req(ok);
    held     = tx_data;
    adc_done = 1'b1;
    adc_data = ~held;
    tick();
    adc_done = 1'b0;
    n_total++;
    if (sample_cnt !== CW'(DP) || sent_cnt !== 3'd0 || tx_req !== 1'b1 || tx_data !== held)
      $display("FAIL stray_adc_done: got cnt=%0d sent=%0d tx_req=%0b data=%0h expected %0d 0 1 %0h",
               sample_cnt, sent_cnt, tx_req, tx_data, DP, held);
    else n_pass++;
    stream(DP, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < DP; i++) vals[i] = DW'($urandom);
    model_start();
    pulse_start();
    capture(0, DP);
    stream(2, 1'b0);
    wait_tx_req(ok);
    n_total++;
    if (sent_cnt !== 3'd2 || tx_req !== 1'b1)
      $display("FAIL pre_reset: got sent=%0d tx_req=%0b expected 2 1", sent_cnt, tx_req);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({adc_req, tx_req, busy, done} !== 4'b0000 || tx_data !== 12'h000 ||
        sample_cnt !== 3'd0 || sent_cnt !== 3'd0)
      $display("FAIL reset_mid: got req=%0b%0b busy=%0b data=%0h cnt=%0d/%0d expected zeros",
               adc_req, tx_req, busy, tx_data, sample_cnt, sent_cnt);
    else n_pass++;
    tick();
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < DP; i++) vals[i] = DW'($urandom);
    model_start();
    pulse_start();
    n_total++;
    if (sample_cnt !== 3'd0 || adc_req !== 1'b1)
      $display("FAIL restart: got cnt=%0d adc_req=%0b expected 0 1", sample_cnt, adc_req);
    else n_pass++;
    capture(0, DP);
    stream(DP, 1'b0);
  endtask

`ifdef THRESH_TRIG_EN
  task automatic test_thresh();
    trig_level = 12'h800;
    trig_model = 12'h800;
    trig_mode  = 1'b1;
    vals[0] = 12'h100; vals[1] = 12'h7FF; vals[2] = 12'h800;
    vals[3] = 12'h900; vals[4] = 12'h0AB; vals[5] = 12'hFFF;
    model_start();
    pulse_start();
    capture(0, 6);
    n_total++;
    if (model_q.size() != DP || model_q[0] !== 12'h800)
      $display("FAIL thresh_model: got size=%0d first=%0h expected %0d 800",
               model_q.size(), model_q[0], DP);
    else n_pass++;
    stream(DP, 1'b0);
    trig_mode = 1'b0;
    trig_level = 12'h000;
  endtask
`endif

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    continuous = 1'b0;
    adc_done   = 1'b0;
    adc_data   = 12'h000;
    tx_done    = 1'b0;
`ifdef THRESH_TRIG_EN
    trig_level = 12'h000;
`endif
    repeat (3) tick();
    test_reset();
    test_basic();
    test_random();
    test_abort();
    test_continuous();
    test_stray();
    test_reset_mid();
`ifdef THRESH_TRIG_EN
    test_thresh();
`endif
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/capture_stream_ctrl.md
Name: capture_stream_ctrl

Overview:
Parametrised capture-then-stream controller between the 12-bit SPI ADC reader and the Arduino SPI writer. On a start request it collects DEPTH samples of DATA_W bits into an internal buffer, then forwards them oldest-first to the Arduino writer one frame at a time. Adds what the fixed 100-sample collector lacked: parametrised width and depth, an explicit start/abort, a continuous re-arm mode, explicit done handshakes, and status counters.

Parameters:
DATA_W, 12, sample width in bits (ADC and Arduino frame payload)
DEPTH, 100, samples per capture; legal range 2..1024
CNT_W, $clog2(DEPTH+1), width of the sample counters

Ports:
clk  in  1  50 MHz system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a capture when in IDLE
abort  in  1  one-cycle pulse; returns to IDLE from any state
continuous  in  1  1 = re-arm capture automatically after transmit; sampled in DONE
adc_req  out  1  request one conversion from the ADC reader
adc_done  in  1  one-cycle pulse from the ADC reader; adc_data valid this cycle
adc_data  in  DATA_W  converted sample
tx_req  out  1  request one frame from the Arduino writer
tx_data  out  DATA_W  frame payload; stable while tx_req=1
tx_done  in  1  one-cycle pulse from the Arduino writer when the frame is finished
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last sample of a capture has been sent
sample_cnt  out  CNT_W  samples stored in the current capture
sent_cnt  out  CNT_W  samples transmitted in the current capture

Behaviour:
- Reset values: adc_req=0, tx_req=0, tx_data=0, busy=0, done=0, sample_cnt=0, sent_cnt=0, state=IDLE, pointers=0. Buffer contents are not reset.
- Buffer: DEPTH x DATA_W register array with write pointer wp and read pointer rp, each 0..DEPTH-1. Transmit order equals capture order.
- IDLE: on start, clear sample_cnt, sent_cnt, wp and rp, then go to ACQ. start is ignored in every other state.
- ACQ: adc_req=1. On adc_done:
  - write adc_data to buf[wp];
  - increment wp and sample_cnt;
  - drop adc_req for exactly one cycle (ACQ_GAP) so the reader sees a new request edge.
  - If sample_cnt reaches DEPTH after the write, go to TX instead of ACQ_GAP.
- ACQ_GAP: adc_req=0 for one cycle, then ACQ.
- TX: tx_data is registered from buf[rp] on entry; tx_req rises the following cycle and is held. On tx_done:
  - tx_req drops;
  - increment rp and sent_cnt;
  - if sent_cnt reaches DEPTH go to DONE, else go to TX_GAP.
- TX_GAP: tx_req=0 for one cycle, then TX.
- DONE: pulse done for one cycle.
  - If continuous=1, clear the counters and pointers and go to ACQ.
  - Otherwise go to IDLE.
- Latency: first adc_req 1 cycle after start. First tx_req 2 cycles after the DEPTH-th adc_done. done asserts 1 cycle after the DEPTH-th tx_done.
- Stray pulses: adc_done outside ACQ and tx_done outside TX are ignored with no state change.
- Simultaneous events: abort has priority over start, adc_done and tx_done in the same cycle. Abort deasserts adc_req and tx_req the next cycle; done is not pulsed; counters hold their values until the next start.
- Pointer wrap: wp and rp wrap DEPTH-1 -> 0 without arithmetic overflow into CNT_W.
- Reset mid-operation forces the reset values immediately, regardless of the peer handshake state.

Optional Feature:
Macro THRESH_TRIG_EN.
- Defined: adds input trig_level [DATA_W-1:0] and state ARM, entered from IDLE on start.
  - ARM requests conversions exactly like ACQ but discards samples while adc_data < trig_level (unsigned).
  - The first sample with adc_data >= trig_level is stored as sample 0, and the block moves to ACQ.
  - With continuous=1, re-arm goes through ARM.
- Not defined: no trig_level port and no ARM state; capture begins with the first conversion.

Test Plan:
- DEPTH=4, start, ADC returns 0x001,0x002,0x003,0x004 -> tx_data sequence 0x001..0x004, sent_cnt 4, one done pulse, busy=0 after.
- Abort asserted in the same cycle as the 2nd adc_done -> sample not counted (sample_cnt=1), adc_req=0 next cycle, no done, state IDLE.
- continuous=1, DEPTH=3, two full cycles with data A then B -> two done pulses, second stream outputs only B values.
- Stray tx_done during ACQ and stray adc_done during TX -> counters and state unchanged.
- Reset asserted while tx_req=1 at sent_cnt=2 -> all outputs 0 immediately; a new start recaptures from sample_cnt=0.
- THRESH_TRIG_EN, trig_level=0x800, ADC stream 0x100,0x7FF,0x800,0x900 -> stored samples start at 0x800, 0x900.
